// File: rtl/nn_pkg.sv
// Shared defaults and helpers for the neural-network datapath blocks.
// Holds the frame geometry defaults, the guard-time derivation that matches
// the downstream maxfinder busy time, and a clog2 helper for counter widths.
package nn_pkg;

   localparam int unsigned NEURON_NUM_DEF = 10;
   localparam int unsigned DATA_WIDTH_DEF = 16;

   typedef enum logic [0:0] {
      StCollect,
      StHold
   } collect_state_e;

   // maxfinder needs one cycle per neuron plus two of pipeline overhead
   function automatic int unsigned guard_cycles(input int unsigned neurons);
      return neurons + 2;
   endfunction

   // Ceiling log2, never narrower than one bit
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) begin
         r = r + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/layer_collector.sv
// Collects NEURON_NUM neuron results into one packed frame for the maxfinder.
// Malformed frames (in_last on the wrong word) are dropped with a frame_err
// pulse. Emissions are spaced by GUARD_CYCLES so the maxfinder is never
// handed a frame while still busy; a frame completed early waits in HOLD.
// Optional build macro COLLECT_RELU_EN: negative inputs are stored as zero.
module layer_collector
   import nn_pkg::*;
#(
   parameter int unsigned NEURON_NUM   = NEURON_NUM_DEF,
   parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int unsigned GUARD_CYCLES = guard_cycles(NEURON_NUM)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_WIDTH-1:0]            in_data,
   input  logic                             in_valid,
   input  logic                             in_last,
   output logic                             in_ready,
   output logic [NEURON_NUM*DATA_WIDTH-1:0] out_data,
   output logic                             out_valid,
   output logic                             frame_err
);

   localparam int unsigned FRAME_W = NEURON_NUM * DATA_WIDTH;
   localparam int unsigned IDX_W   = clog2(NEURON_NUM);
   localparam int unsigned GRD_W   = clog2(GUARD_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NEURON_NUM - 1);
   localparam logic [GRD_W-1:0] GUARD_LOAD = GRD_W'(GUARD_CYCLES);

   collect_state_e       state_q, state_d;
   logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
   logic [GRD_W-1:0]     guard_q, guard_d;
   logic [FRAME_W-1:0]   col_q, col_d;
   logic [FRAME_W-1:0]   out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic                 frame_err_q, frame_err_d;

   logic                 accept;
   logic                 at_last_idx;
   logic                 frame_done;
   logic                 frame_bad;
   logic                 emit;
   logic [DATA_WIDTH-1:0] word;

   // Handshake and frame classification of the word offered this cycle
   always_comb begin
      in_ready    = (state_q == StCollect) && !rst;
      accept      = in_valid && in_ready;
      at_last_idx = (wr_idx_q == LAST_IDX);
      frame_done  = accept && at_last_idx && in_last;
      frame_bad   = accept && (at_last_idx != in_last);
   end

   // Word as stored in the collect buffer
   always_comb begin
      word = in_data;
`ifdef COLLECT_RELU_EN
      // Clamp negatives so the unsigned max compare downstream stays correct
      if (in_data[DATA_WIDTH-1]) begin
         word = '0;
      end
`endif
   end

   // Next-state: buffer fill, FSM, emission and guard countdown
   always_comb begin
      col_d    = col_q;
      wr_idx_d = wr_idx_q;
      state_d  = state_q;
      emit     = 1'b0;

      if (accept) begin
         for (int k = 0; k < int'(NEURON_NUM); k++) begin
            if (wr_idx_q == IDX_W'(k)) begin
               col_d[k*DATA_WIDTH +: DATA_WIDTH] = word;
            end
         end
         if (frame_done || frame_bad) begin
            wr_idx_d = '0;
         end else begin
            wr_idx_d = wr_idx_q + 1'b1;
         end
      end

      unique case (state_q)
         StCollect: begin
            if (frame_done) begin
               if (guard_q == '0) begin
                  emit = 1'b1;
               end else begin
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (guard_q == '0) begin
               emit    = 1'b1;
               state_d = StCollect;
            end
         end
         default: state_d = StCollect;
      endcase

      out_valid_d = emit;
      frame_err_d = frame_bad;
      // col_d already holds the word accepted this cycle
      out_data_d  = emit ? col_d : out_data_q;

      if (emit) begin
         guard_d = GUARD_LOAD;
      end else if (guard_q != '0) begin
         guard_d = guard_q - 1'b1;
      end else begin
         guard_d = '0;
      end
   end

   // State registers; reset discards any partial or pending frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StCollect;
         wr_idx_q    <= '0;
         guard_q     <= '0;
         col_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_idx_q    <= wr_idx_d;
         guard_q     <= guard_d;
         col_q       <= col_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_layer_collector.sv
// Self-checking bench for layer_collector: directed frames plus randomized
// gaps, checked cycle by cycle against a frame-level reference model.
module tb_layer_collector;

   localparam int unsigned N  = 10;
   localparam int unsigned DW = 16;
   localparam int unsigned G  = N + 2;
   localparam int unsigned OW = N * DW;

   logic          clk;
   logic          rst;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic [OW-1:0] out_data;
   logic          out_valid;
   logic          frame_err;

   layer_collector #(
      .NEURON_NUM   (N),
      .DATA_WIDTH   (DW),
      .GUARD_CYCLES (G)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [DW-1:0] q[$];
   int            cyc;
   int            last_emit;
   bit            pending;
   int            pend_at;
   logic [OW-1:0] pend_frame;
   logic [OW-1:0] exp_data;
   bit            exp_valid;
   bit            exp_err;
   // Observations of the DUT
   int            obs_last;
   int            obs_prev;
   logic [OW-1:0] captured;

   task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] relu(input logic [DW-1:0] d);
`ifdef COLLECT_RELU_EN
      return d[DW-1] ? '0 : d;
`else
      return d;
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      cyc       = 0;
      last_emit = -1000;
      pending   = 0;
      pend_at   = 0;
      exp_data  = '0;
      obs_last  = -1;
      obs_prev  = -1;
   endtask

   // One clock cycle: drive, predict, then check registered outputs
   task automatic step(input bit v, input logic [DW-1:0] d, input bit l, output bit acc);
      bit            ready_exp;
      logic [OW-1:0] fr;
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      in_last  = l;
      ready_exp = !pending;
      check("in_ready", OW'(in_ready), OW'(ready_exp));
      acc       = v && ready_exp;
      exp_valid = 0;
      exp_err   = 0;
      if (pending && (cyc + 1 == pend_at)) begin
         exp_valid = 1;
         exp_data  = pend_frame;
         last_emit = cyc + 1;
         pending   = 0;
      end
      if (acc) begin
         q.push_back(relu(d));
         if (q.size() == N || l) begin
            if (q.size() == N && l) begin
               fr = '0;
               for (int i = 0; i < int'(N); i++) fr[i*DW +: DW] = q[i];
               if (cyc + 1 >= last_emit + int'(G) + 1) begin
                  exp_valid = 1;
                  exp_data  = fr;
                  last_emit = cyc + 1;
               end else begin
                  pending    = 1;
                  pend_frame = fr;
                  pend_at    = last_emit + int'(G) + 1;
               end
            end else begin
               exp_err = 1;
            end
            q.delete();
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      check("out_valid", OW'(out_valid), OW'(exp_valid));
      check("frame_err", OW'(frame_err), OW'(exp_err));
      check("out_data", out_data, exp_data);
      if (out_valid) begin
         if (obs_last >= 0) check("spacing_ok", OW'(cyc - obs_last >= int'(G) + 1), OW'(1));
         obs_prev = obs_last;
         obs_last = cyc;
         captured = out_data;
      end
   endtask

   task automatic send_word(input logic [DW-1:0] d, input bit l);
      bit acc;
      int tries;
      tries = 0;
      do begin
         step(1'b1, d, l, acc);
         tries++;
      end while (!acc && tries < 50);
      check("send_accept", OW'(acc), OW'(1));
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, DW'($urandom), 1'b0, acc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      #1;
      check("rst_in_ready", OW'(in_ready), OW'(0));
      check("rst_out_valid", OW'(out_valid), OW'(0));
      check("rst_frame_err", OW'(frame_err), OW'(0));
      check("rst_out_data", out_data, OW'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] w;
      int            amax;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      captured = '0;
      model_reset();
      repeat (3) @(posedge clk);
      do_reset();

      // Frame 1..10 with idle guard
      for (int k = 1; k <= int'(N); k++) send_word(DW'(k), k == int'(N));
      idle(1);
      check("f1_word0", OW'(captured[15:0]), OW'(1));
      check("f1_word9", OW'(captured[159:144]), OW'(10));
      amax = 0;
      for (int i = 1; i < int'(N); i++) begin
         if (captured[i*DW +: DW] > captured[amax*DW +: DW]) amax = i;
      end
      check("f1_argmax", OW'(amax), OW'(9));
      idle(20);

      // Back-to-back frames at full rate: second one waits in HOLD
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < int'(N); k++) send_word(DW'($urandom), k == int'(N) - 1);
      end
      idle(20);
      check("b2b_gap", OW'(obs_last - obs_prev), OW'(G + 1));

      // Early in_last on word 4, then a clean frame
      for (int k = 0; k < 4; k++) send_word(DW'(100 + k), k == 3);
      idle(3);
      for (int k = 0; k < int'(N); k++) send_word(DW'(200 + k), k == int'(N) - 1);
      idle(2);
      check("after_err_word0", OW'(captured[15:0]), OW'(200));
      // Missing in_last on the final word
      for (int k = 0; k < int'(N); k++) send_word(DW'(300 + k), 1'b0);
      idle(20);

      // Negative value at index 3
      for (int k = 0; k < int'(N); k++) send_word((k == 3) ? 16'hFFF0 : DW'(k), k == int'(N) - 1);
      idle(2);
`ifdef COLLECT_RELU_EN
      check("relu_idx3", OW'(captured[63:48]), OW'(16'h0000));
`else
      check("relu_idx3", OW'(captured[63:48]), OW'(16'hFFF0));
`endif
      idle(20);

      // Reset mid-frame, then a full frame of fresh words
      for (int k = 0; k < 6; k++) send_word(DW'(500 + k), 1'b0);
      do_reset();
      for (int k = 0; k < int'(N); k++) send_word(DW'(600 + k), k == int'(N) - 1);
      idle(2);
      check("post_rst_word0", OW'(captured[15:0]), OW'(600));

      // Reset while a frame is held
      idle(20);
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < int'(N); k++) send_word(DW'($urandom), k == int'(N) - 1);
      end
      do_reset();
      idle(20);

      // Randomized gaps over 20 frames
      for (int f = 0; f < 20; f++) begin
         for (int k = 0; k < int'(N); k++) begin
            for (int g = 0; g < 8 && $urandom_range(1, 0) == 1; g++) idle(1);
            w = DW'($urandom);
            send_word(w, k == int'(N) - 1);
         end
      end
      idle(30);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/layer_collector.md
LAYER_COLLECTOR -- requirements
Module: layer_collector

Interface
REQ-001 SHALL have parameter NEURON_NUM, default 10: number of neuron results per frame.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: width of one neuron result.
REQ-003 SHALL have parameter GUARD_CYCLES, default NEURON_NUM+2: minimum cycles between out_valid pulses, matching the downstream maxfinder busy time.
REQ-004 SHALL have a single clock, with reset asynchronous and active-high; there are no other clock or reset inputs.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_data  in  DATA_WIDTH  one neuron result.
REQ-008 in_valid  in  1  in_data/in_last valid.
REQ-009 in_last  in  1  marks the final result of a frame.
REQ-010 in_ready  out  1  block can accept a word.
REQ-011 out_data  out  NEURON_NUM*DATA_WIDTH  packed frame; feeds maxfinder data_in.
REQ-012 out_valid  out  1  one-cycle pulse; out_data is a new frame; feeds maxfinder data_valid.
REQ-013 frame_err  out  1  one-cycle pulse; a malformed frame was dropped.

Function
REQ-014 SHALL transfer a word on any rising edge with in_valid=1 and in_ready=1.
REQ-015 SHALL store the k-th accepted word of a frame (k = 0..NEURON_NUM-1) at collect-buffer bits [k*DATA_WIDTH +: DATA_WIDTH], tracked by counter wr_idx.
REQ-016 SHALL treat a word as frame-complete when it is accepted with wr_idx=NEURON_NUM-1 and in_last=1; wr_idx then returns to 0.
REQ-017 SHALL treat a word as an error when it is accepted with in_last=1 and wr_idx≠NEURON_NUM-1, or with wr_idx=NEURON_NUM-1 and in_last=0.
REQ-018 On an error word, SHALL consume the word, pulse frame_err in the next cycle, reset wr_idx to 0, and not assert out_valid for that frame.
REQ-019 SHALL implement a 2-state FSM:
- COLLECT: in_ready=1.
- HOLD: in_ready=0; a complete frame is pending.
REQ-020 SHALL maintain guard_cnt: loaded with GUARD_CYCLES on every emission, decremented by 1 each cycle while nonzero, saturating at 0.
REQ-021 Frame complete in cycle T with guard_cnt=0 in T: SHALL copy the collect buffer (including the word accepted in T) to out_data and assert out_valid in cycle T+1; the FSM stays in COLLECT.
REQ-022 Frame complete in cycle T with guard_cnt≠0 in T: SHALL go to HOLD at T+1.
REQ-023 In HOLD, in the first cycle with guard_cnt=0, SHALL emit in the following cycle (out_data updated, out_valid=1) and return to COLLECT.
REQ-024 Accepting words of the next frame SHALL be allowed during the guard period while in COLLECT; out_data SHALL NOT change during the guard period.
REQ-025 out_data SHALL hold the last emitted frame until the next emission.
REQ-026 out_valid SHALL never be high in two cycles less than GUARD_CYCLES+1 apart.

Reset
REQ-027 While rst=1, SHALL force: out_data=0, out_valid=0, frame_err=0, in_ready=0, state=COLLECT, wr_idx=0, guard_cnt=0, collect buffer=0.
REQ-028 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-029 Reset mid-frame or in HOLD SHALL discard the partial or pending frame without an out_valid pulse.

Configuration
REQ-030 SHALL provide macro COLLECT_RELU_EN.
- Defined: any in_data with MSB=1 (negative two's complement) is stored as 0, so the downstream unsigned max compare is correct.
- Undefined: in_data is stored verbatim.
- Framing, latency and error behaviour SHALL be identical either way.

Structure
REQ-031 Shared package nn_pkg SHALL hold the NEURON_NUM and DATA_WIDTH defaults, the GUARD_CYCLES derivation and a clog2 helper for the wr_idx and guard_cnt widths.
REQ-032 SHALL be a single module with no sub-module; the FSM, counters and buffers are inline.

Verification
REQ-033 Frame 1..10 (DATA_WIDTH=16), last on word 10, idle guard -> out_valid at T+1 with out_data[15:0]=1 and out_data[159:144]=10; maxfinder reports index 9.
REQ-034 Two back-to-back frames at full rate -> second frame goes to HOLD; out_valid pulses exactly GUARD_CYCLES+1=13 cycles apart; in_ready low only during HOLD.
REQ-035 in_last on word 4 -> frame_err one-cycle pulse, no out_valid; next correct 10-word frame is emitted normally.
REQ-036 With COLLECT_RELU_EN defined, input 16'hFFF0 at index 3 -> out_data[63:48]=0; without it -> 16'hFFF0.
REQ-037 rst asserted after word 6, then a complete frame -> no stale out_valid; the emitted frame contains only post-reset words.
REQ-038 Random in_valid gaps (50% duty) over 20 frames -> every out_data matches the scoreboard and the out_valid spacing rule holds.
